pushbutton_mode_ctrl: RTL and testbench

PUSHBUTTON_MODE_CTRL -- requirements
Module: pushbutton_mode_ctrl

---
 rtl/pushbutton_mode_ctrl.sv | 90 +++++++++
 tb/tb_pushbutton_mode_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_mode_ctrl.sv
// Two-button mode selector: synchronizes and debounces the buttons,
// then latches the ALU operands and the AND/ADD select on each press.
module pushbutton_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_raw,
    input  logic       right_raw,
    input  logic [3:0] A_in,
    input  logic [3:0] B_in,
    output logic       left_pushbutton,
    output logic       right_pushbutton,
    output logic [3:0] A,
    output logic [3:0] B
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        AND_MODE = 2'b01,
        ADD_MODE = 2'b10
    } state_t;

    // Bit 0 is the left button, bit 1 the right button.
    logic [1:0]    raw;
    logic [1:0]    sync_1;
    logic [1:0]    sync_x;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    ev;
    logic [CW-1:0] cnt [2];
    state_t        state;

    assign raw = {right_raw, left_raw};
    assign ev  = deb & ~deb_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_x <= '0;
            deb    <= '0;
            deb_d  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_1 <= raw;
            sync_x <= sync_1;
            deb_d  <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_x[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Events are taken from the registered deb edge, one cycle after the toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            A     <= '0;
            B     <= '0;
        end else begin
            if (ev == 2'b11) begin
                state <= IDLE;
            end else if (ev[0]) begin
                state <= AND_MODE;
                A     <= A_in;
                B     <= B_in;
            end else if (ev[1]) begin
                state <= ADD_MODE;
                A     <= A_in;
                B     <= B_in;
            end
        end
    end

    assign left_pushbutton  = state[0];
    assign right_pushbutton = state[1];

endmodule

// File: tb/tb_pushbutton_mode_ctrl.sv
// Randomized scoreboard bench for pushbutton_mode_ctrl against a
// window-based reference model of the debounce and mode rules.
module tb_pushbutton_mode_ctrl;

    localparam int D = 4;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       left_raw = 1'b0;
    logic       right_raw = 1'b0;
    logic [3:0] A_in = 4'h0;
    logic [3:0] B_in = 4'h0;
    logic       left_pushbutton;
    logic       right_pushbutton;
    logic [3:0] A;
    logic [3:0] B;

    int total = 0;
    int bad = 0;

    pushbutton_mode_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .left_raw         (left_raw),
        .right_raw        (right_raw),
        .A_in             (A_in),
        .B_in             (B_in),
        .left_pushbutton  (left_pushbutton),
        .right_pushbutton (right_pushbutton),
        .A                (A),
        .B                (B)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic       r;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 AND, 2 ADD.
    bit         hl[$];
    bit         hr[$];
    bit         m_deb_l;
    bit         m_deb_r;
    bit         pend_l;
    bit         pend_r;
    int         m_mode;
    logic [3:0] m_a;
    logic [3:0] m_b;

    function automatic bit accepted(input bit h[$], input bit cur);
        // A level is accepted once the synchronized input (two edges late)
        // has disagreed with the debounced level for D edges in a row.
        for (int k = 0; k < D; k++) begin
            if (h[k] == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hl.delete();
        hr.delete();
        for (int k = 0; k < D + 2; k++) begin
            hl.push_back(1'b0);
            hr.push_back(1'b0);
        end
        m_deb_l = 0;
        m_deb_r = 0;
        pend_l  = 0;
        pend_r  = 0;
        m_mode  = 0;
        m_a     = 4'h0;
        m_b     = 4'h0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            model_reset();
        end else begin
            if (pend_l && pend_r) begin
                m_mode = 0;
            end else if (pend_l || pend_r) begin
                m_mode = pend_l ? 1 : 2;
                m_a    = A_in;
                m_b    = B_in;
            end
            pend_l = 0;
            pend_r = 0;
            hl.push_back(left_raw);
            void'(hl.pop_front());
            hr.push_back(right_raw);
            void'(hr.pop_front());
            if (accepted(hl, m_deb_l)) begin
                pend_l  = !m_deb_l;
                m_deb_l = !m_deb_l;
            end
            if (accepted(hr, m_deb_r)) begin
                pend_r  = !m_deb_r;
                m_deb_r = !m_deb_r;
            end
        end
        e.l = (m_mode == 1);
        e.r = (m_mode == 2);
        e.a = m_a;
        e.b = m_b;
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("left_sel", {3'b0, left_pushbutton}, {3'b0, e.l});
            check("right_sel", {3'b0, right_pushbutton}, {3'b0, e.r});
            check("A", A, e.a);
            check("B", B, e.b);
            check("sel_exclusive", {3'b0, left_pushbutton & right_pushbutton}, 4'h0);
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_left"}, {3'b0, left_pushbutton}, 4'h0);
        check({tag, "_right"}, {3'b0, right_pushbutton}, 4'h0);
        check({tag, "_A"}, A, 4'h0);
        check({tag, "_B"}, B, 4'h0);
    endtask

    // Called just after an active edge: asserts reset mid-cycle.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check_zero(tag);
    endtask

    // Counts edges until {right,left} equals code; inputs already driven.
    task automatic measure(input string tag, input logic [1:0] code);
        int n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if ({right_pushbutton, left_pushbutton} == code) break;
        end
        check(tag, 4'(n), 4'(LAT));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with a button held and switches at all-ones.
        left_raw = 1'b1;
        A_in = 4'hF;
        B_in = 4'hF;
        idle_cycles(3);
        check_zero("in_reset");
        left_raw = 1'b0;
        reset = 1'b0;
        idle_cycles(4);

        // Clean left press.
        A_in = 4'b1100;
        B_in = 4'b1010;
        left_raw = 1'b1;
        measure("lat_left", 2'b01);
        check("press_A", A, 4'b1100);
        check("press_B", B, 4'b1010);
        idle_cycles(3);
        left_raw = 1'b0;
        idle_cycles(8);

        // Glitch on the right button.
        A_in = 4'h7;
        right_raw = 1'b1;
        idle_cycles(3);
        right_raw = 1'b0;
        idle_cycles(10);
        check("glitch_right", {3'b0, right_pushbutton}, 4'h0);
        check("glitch_A", A, 4'b1100);

        // Switch to ADD mode.
        A_in = 4'b0001;
        B_in = 4'b0011;
        right_raw = 1'b1;
        measure("lat_right", 2'b10);
        check("switch_A", A, 4'b0001);
        check("switch_B", B, 4'b0011);
        idle_cycles(2);
        right_raw = 1'b0;

        // Switch changes without a press, then both buttons at once.
        A_in = 4'hE;
        B_in = 4'hD;
        idle_cycles(8);
        check("hold_A", A, 4'b0001);
        left_raw = 1'b1;
        right_raw = 1'b1;
        measure("lat_both", 2'b00);
        check("both_A", A, 4'b0001);
        check("both_B", B, 4'b0011);
        idle_cycles(2);
        left_raw = 1'b0;
        right_raw = 1'b0;
        idle_cycles(8);

        // Reset two cycles into a left press, button held through release.
        A_in = 4'h5;
        B_in = 4'h9;
        left_raw = 1'b1;
        @(posedge clk);
        @(posedge clk);
        async_reset("async_mid");
        idle_cycles(3);
        reset = 1'b0;
        measure("lat_after_reset", 2'b01);
        check("after_reset_A", A, 4'h5);
        idle_cycles(2);

        // Random phase, with bursts of bouncing and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            int bounce;
            @(negedge clk);
            bounce = ((i / 200) % 2 == 0) ? 3 : 12;
            if ($urandom_range(bounce - 1, 0) == 0) left_raw = ~left_raw;
            if ($urandom_range(bounce - 1, 0) == 0) right_raw = ~right_raw;
            if ($urandom_range(3, 0) == 0) A_in = 4'($urandom);
            if ($urandom_range(3, 0) == 0) B_in = 4'($urandom);
            if ($urandom_range(599, 0) == 0) begin
                async_reset("async_rand");
                idle_cycles(2);
                reset = 1'b0;
            end
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
